// File: rtl/video_vram_arbiter.sv
// ---------------------------------------------------------------------------
// video_vram_arbiter
//
// Shares the PPU's 14-bit multiplexed VRAM bus between the rendering fetch
// pipeline and CPU PPUDATA accesses. Every bus access takes two dots: an
// address dot (ALE high) followed by a data dot (rd_n or wr_n low). Rendering
// fetches always own the bus. A one-deep CPU request buffer drains only while
// rendering is off and no fetch phase is active.
//
// Optional feature macro: VIDEO_VRAM_READ_BUFFER_EN
//   defined   : PPUDATA delayed-read semantics. A read returns the previous
//               content of an internal read buffer, except palette addresses
//               (addr[13:8] = 6'h3F), which return fresh data. The buffer
//               always loads the fresh byte.
//   undefined : a read returns the byte fetched by that access.
//
// Ports:
//   I_clock, I_reset   clock, synchronous active-high reset
//   I_clk_rise         dot enable; the FSM advances only when high
//   I_control[15:0]    [7:0] fetch phases (odd = address, even = data),
//                      [10] rendering flag
//   I_render_addr      fetch address, sampled on an address phase
//   O_render_data      fetched byte; O_render_valid pulses when it updates
//   O_render_miss      pulse: a render address phase was dropped because a
//                      CPU access held the bus
//   I_cpu_req/we/addr/wdata  CPU request strobe and payload
//   O_cpu_busy         request buffer occupied
//   O_cpu_ack          pulse on CPU access completion
//   O_cpu_rdata        read result, held until the next read completes
//   O_vram_*           external bus: addr, ale, rd_n, wr_n, wdata, oe
//   I_vram_rdata       external bus read data
//   O_dbg_state        current FSM state encoding
//
// CPU handshake: I_cpu_req is a one-clock strobe accepted on any clock while
// O_cpu_busy is low, or on the clock in which the current access completes
// (O_cpu_ack then pulses with O_cpu_busy still high). Strobes arriving while
// busy otherwise are ignored; nothing is queued beyond the single buffer.
// ---------------------------------------------------------------------------
module video_vram_arbiter #(
    parameter int P_addr_width = 14,
    parameter int P_data_width = 8
) (
    input  logic                    I_clock,
    input  logic                    I_reset,
    input  logic                    I_clk_rise,
    input  logic [15:0]             I_control,
    input  logic [P_addr_width-1:0] I_render_addr,
    output logic [P_data_width-1:0] O_render_data,
    output logic                    O_render_valid,
    output logic                    O_render_miss,
    input  logic                    I_cpu_req,
    input  logic                    I_cpu_we,
    input  logic [P_addr_width-1:0] I_cpu_addr,
    input  logic [P_data_width-1:0] I_cpu_wdata,
    output logic                    O_cpu_busy,
    output logic                    O_cpu_ack,
    output logic [P_data_width-1:0] O_cpu_rdata,
    output logic [P_addr_width-1:0] O_vram_addr,
    output logic                    O_vram_ale,
    output logic                    O_vram_rd_n,
    output logic                    O_vram_wr_n,
    output logic [P_data_width-1:0] O_vram_wdata,
    output logic                    O_vram_oe,
    input  logic [P_data_width-1:0] I_vram_rdata,
    output logic [2:0]              O_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_R_ADDR = 3'd1,
        S_R_DATA = 3'd2,
        S_C_ADDR = 3'd3,
        S_C_DATA = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // Request buffer
    logic                    r_pending;
    logic                    r_buf_we;
    logic [P_addr_width-1:0] r_buf_addr;
    logic [P_data_width-1:0] r_buf_wdata;

    // Registered outputs
    logic [P_addr_width-1:0] r_vram_addr;
    logic [P_data_width-1:0] r_vram_wdata;
    logic [P_data_width-1:0] r_render_data;
    logic                    r_render_valid;
    logic                    r_render_miss;
    logic                    r_cpu_ack;
    logic [P_data_width-1:0] r_cpu_rdata;

    // Decoded control and FSM strobes
    logic                    w_rendering;
    logic                    w_addr_phase;
    logic                    w_cpu_eligible;
    logic                    w_latch_render;
    logic                    w_latch_cpu;
    logic                    w_render_done;
    logic                    w_cpu_done;
    logic                    w_miss;
    logic                    w_accept_req;
    logic                    w_unused;

    assign w_rendering    = I_control[10];
    assign w_addr_phase   = w_rendering &
                            (I_control[1] | I_control[3] | I_control[5] | I_control[7]);
    assign w_cpu_eligible = r_pending & ~w_rendering & (I_control[7:0] == 8'd0);
    assign w_unused       = ^{I_control[15:11], I_control[9:8]};

    // A completing access frees the buffer in the same clock, so a strobe
    // coinciding with completion is accepted rather than lost.
    assign w_accept_req   = I_cpu_req & (~r_pending | w_cpu_done);

    always_comb begin
        w_next_state   = r_state;
        w_latch_render = 1'b0;
        w_latch_cpu    = 1'b0;
        w_render_done  = 1'b0;
        w_cpu_done     = 1'b0;
        w_miss         = 1'b0;
        if (I_clk_rise) begin
            case (r_state)
                S_IDLE: begin
                    if (w_addr_phase) begin
                        w_next_state   = S_R_ADDR;
                        w_latch_render = 1'b1;
                    end else if (w_cpu_eligible) begin
                        w_next_state = S_C_ADDR;
                        w_latch_cpu  = 1'b1;
                    end
                end
                S_R_ADDR: w_next_state = S_R_DATA;
                S_R_DATA: begin
                    w_render_done = 1'b1;
                    // Back-to-back fetch: chain straight into the next address dot.
                    if (w_addr_phase) begin
                        w_next_state   = S_R_ADDR;
                        w_latch_render = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_C_ADDR: begin
                    w_next_state = S_C_DATA;
                    w_miss       = w_addr_phase;
                end
                S_C_DATA: begin
                    w_next_state = S_IDLE;
                    w_cpu_done   = 1'b1;
                    w_miss       = w_addr_phase;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state        <= S_IDLE;
            r_pending      <= 1'b0;
            r_buf_we       <= 1'b0;
            r_buf_addr     <= '0;
            r_buf_wdata    <= '0;
            r_vram_addr    <= '0;
            r_vram_wdata   <= '0;
            r_render_data  <= '0;
            r_render_valid <= 1'b0;
            r_render_miss  <= 1'b0;
            r_cpu_ack      <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_render_valid <= w_render_done;
            r_render_miss  <= w_miss;
            r_cpu_ack      <= w_cpu_done;

            if (w_latch_render) begin
                r_vram_addr <= I_render_addr;
            end else if (w_latch_cpu) begin
                r_vram_addr <= r_buf_addr;
                if (r_buf_we) begin
                    r_vram_wdata <= r_buf_wdata;
                end
            end

            if (w_render_done) begin
                r_render_data <= I_vram_rdata;
            end

            if (w_accept_req) begin
                r_pending   <= 1'b1;
                r_buf_we    <= I_cpu_we;
                r_buf_addr  <= I_cpu_addr;
                r_buf_wdata <= I_cpu_wdata;
            end else if (w_cpu_done) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef VIDEO_VRAM_READ_BUFFER_EN
    logic [P_data_width-1:0] r_read_buf;
    logic                    w_palette;

    // r_buf_addr is still the completing access here: a new request loads
    // it on the same edge, so the old value is what this edge sees.
    assign w_palette = (r_buf_addr[P_addr_width-1 -: 6] == 6'h3F);

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_read_buf  <= '0;
            r_cpu_rdata <= '0;
        end else if (w_cpu_done && !r_buf_we) begin
            r_cpu_rdata <= w_palette ? I_vram_rdata : r_read_buf;
            r_read_buf  <= I_vram_rdata;
        end
    end
`else
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_cpu_rdata <= '0;
        end else if (w_cpu_done && !r_buf_we) begin
            r_cpu_rdata <= I_vram_rdata;
        end
    end
`endif

    // Bus strobes are decoded from the current state, so they are inactive
    // in IDLE and fall back to idle levels as soon as an access ends.
    assign O_vram_ale   = (r_state == S_R_ADDR) || (r_state == S_C_ADDR);
    assign O_vram_rd_n  = ~((r_state == S_R_DATA) || ((r_state == S_C_DATA) && !r_buf_we));
    assign O_vram_wr_n  = ~((r_state == S_C_DATA) && r_buf_we);
    assign O_vram_oe    = (r_state == S_C_DATA) && r_buf_we;
    assign O_vram_addr  = r_vram_addr;
    assign O_vram_wdata = r_vram_wdata;

    assign O_render_data  = r_render_data;
    assign O_render_valid = r_render_valid;
    assign O_render_miss  = r_render_miss;
    assign O_cpu_busy     = r_pending;
    assign O_cpu_ack      = r_cpu_ack;
    assign O_cpu_rdata    = r_cpu_rdata;
    assign O_dbg_state    = r_state;

endmodule

// File: tb/tb_video_vram_arbiter.sv
`timescale 1ns/1ps
module tb_video_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;
    // {addr, ale, rd_n, wr_n, oe, wdata, busy, ack, cpu_rdata, render_data, valid, miss}
    localparam logic [45:0] RST_OUT = {14'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00,
                                       1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    // ---------------- clock / reset / DUT ----------------
    logic          I_clock = 1'b0;
    logic          I_reset = 1'b0;
    logic          I_clk_rise = 1'b0;
    logic [15:0]   I_control = 16'h0;
    logic [AW-1:0] I_render_addr = '0;
    logic [DW-1:0] O_render_data;
    logic          O_render_valid;
    logic          O_render_miss;
    logic          I_cpu_req = 1'b0;
    logic          I_cpu_we = 1'b0;
    logic [AW-1:0] I_cpu_addr = '0;
    logic [DW-1:0] I_cpu_wdata = '0;
    logic          O_cpu_busy;
    logic          O_cpu_ack;
    logic [DW-1:0] O_cpu_rdata;
    logic [AW-1:0] O_vram_addr;
    logic          O_vram_ale;
    logic          O_vram_rd_n;
    logic          O_vram_wr_n;
    logic [DW-1:0] O_vram_wdata;
    logic          O_vram_oe;
    logic [DW-1:0] I_vram_rdata;
    logic [2:0]    O_dbg_state;

    always #5 I_clock = ~I_clock;

    video_vram_arbiter dut (
        .I_clock        (I_clock),
        .I_reset        (I_reset),
        .I_clk_rise     (I_clk_rise),
        .I_control      (I_control),
        .I_render_addr  (I_render_addr),
        .O_render_data  (O_render_data),
        .O_render_valid (O_render_valid),
        .O_render_miss  (O_render_miss),
        .I_cpu_req      (I_cpu_req),
        .I_cpu_we       (I_cpu_we),
        .I_cpu_addr     (I_cpu_addr),
        .I_cpu_wdata    (I_cpu_wdata),
        .O_cpu_busy     (O_cpu_busy),
        .O_cpu_ack      (O_cpu_ack),
        .O_cpu_rdata    (O_cpu_rdata),
        .O_vram_addr    (O_vram_addr),
        .O_vram_ale     (O_vram_ale),
        .O_vram_rd_n    (O_vram_rd_n),
        .O_vram_wr_n    (O_vram_wr_n),
        .O_vram_wdata   (O_vram_wdata),
        .O_vram_oe      (O_vram_oe),
        .I_vram_rdata   (I_vram_rdata),
        .O_dbg_state    (O_dbg_state)
    );

    wire [45:0] w_out_vec = {O_vram_addr, O_vram_ale, O_vram_rd_n, O_vram_wr_n, O_vram_oe,
                             O_vram_wdata, O_cpu_busy, O_cpu_ack, O_cpu_rdata,
                             O_render_data, O_render_valid, O_render_miss};

    // ---------------- external VRAM and reference model ----------------
    logic [DW-1:0] vram      [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [DW-1:0] rb_model = '0;

    assign I_vram_rdata = vram[O_vram_addr];

    // The bus write takes effect on the dot-enable edge while wr_n is low.
    always @(negedge I_clock) begin
        if (I_clk_rise && !O_vram_wr_n && O_vram_oe) vram[O_vram_addr] = O_vram_wdata;
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            passes = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int            miss_cnt = 0;

    always @(negedge I_clock) begin
        if (O_render_valid) obs_q.push_back(O_render_data);
        if (O_render_miss) miss_cnt <= miss_cnt + 1;
    end

    // Expected PPUDATA read result from the memory image and read-buffer rules.
    task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] exp);
`ifdef VIDEO_VRAM_READ_BUFFER_EN
        exp = (a[13:8] == 6'h3F) ? model_mem[a] : rb_model;
        rb_model = model_mem[a];
`else
        exp = model_mem[a];
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic rise);
        I_clk_rise = rise;
        @(posedge I_clock);
        #1;
    endtask

    task automatic dot();
        tick(1'b0);
        tick(1'b1);
    endtask

    task automatic do_reset();
        I_reset = 1'b1;
        I_cpu_req = 1'b0;
        I_control = 16'h0;
        tick(1'b0);
        tick(1'b0);
        I_reset = 1'b0;
        tick(1'b0);
        rb_model = '0;
    endtask

    task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        vram[a] = d;
        model_mem[a] = d;
    endtask

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        bit got;
        I_cpu_we = we;
        I_cpu_addr = a;
        I_cpu_wdata = d;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        got = 0;
        for (int k = 0; k < 24 && !got; k++) begin
            tick(k[0]);
            if (O_cpu_ack) got = 1;
        end
        checks++;
        if (!got) $display("FAIL cpu_ack_timeout addr=%h: ack=0 required=1", a);
        else passes++;
        checks++;
        if (O_cpu_busy !== 1'b0) $display("FAIL cpu_busy_at_ack addr=%h: got %b required 0", a, O_cpu_busy);
        else passes++;
        if (we) begin
            model_mem[a] = d;
        end else begin
            model_read(a, exp);
            checks++;
            if (O_cpu_rdata !== exp) $display("FAIL cpu_rdata addr=%h: got %h required %h", a, O_cpu_rdata, exp);
            else passes++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (w_out_vec !== RST_OUT || O_dbg_state !== 3'd0)
            $display("FAIL reset_values: got %h/%0d required %h/0", w_out_vec, O_dbg_state, RST_OUT);
        else passes++;
        for (int i = 0; i < 4; i++) dot();
        checks++;
        if (w_out_vec !== RST_OUT) $display("FAIL idle_dots: got %h required %h", w_out_vec, RST_OUT);
        else passes++;
    endtask

    task automatic test_render_fetch();
        int ob;
        do_reset();
        ob = obs_q.size();
        set_mem(14'h2000, 8'h5A);
        I_control = 16'h0402;
        I_render_addr = 14'h2000;
        dot();
        checks++;
        if ({O_vram_ale, O_vram_addr, O_vram_rd_n} !== {1'b1, 14'h2000, 1'b1})
            $display("FAIL render_addr_dot: ale=%b addr=%h rd_n=%b required 1 2000 1", O_vram_ale, O_vram_addr, O_vram_rd_n);
        else passes++;
        I_control = 16'h0404;
        I_render_addr = 14'h1234;
        dot();
        checks++;
        if ({O_vram_ale, O_vram_rd_n, O_vram_addr} !== {1'b0, 1'b0, 14'h2000})
            $display("FAIL render_data_dot: ale=%b rd_n=%b addr=%h required 0 0 2000", O_vram_ale, O_vram_rd_n, O_vram_addr);
        else passes++;
        I_control = 16'h0400;
        dot();
        checks++;
        if ({O_render_valid, O_render_data, O_vram_rd_n} !== {1'b1, 8'h5A, 1'b1})
            $display("FAIL render_valid: valid=%b data=%h rd_n=%b required 1 5a 1", O_render_valid, O_render_data, O_vram_rd_n);
        else passes++;
        tick(1'b0);
        checks++;
        if (O_render_valid !== 1'b0 || obs_q.size() != ob + 1)
            $display("FAIL render_pulse_width: valid=%b pulses=%0d required 0 1", O_render_valid, obs_q.size() - ob);
        else passes++;
    endtask

    task automatic test_cpu_write();
        do_reset();
        I_cpu_we = 1'b1;
        I_cpu_addr = 14'h3F00;
        I_cpu_wdata = 8'h21;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        checks++;
        if (O_cpu_busy !== 1'b1 || O_vram_ale !== 1'b0) $display("FAIL wr_busy: busy=%b ale=%b required 1 0", O_cpu_busy, O_vram_ale);
        else passes++;
        dot();
        checks++;
        if ({O_vram_ale, O_vram_addr, O_vram_wr_n} !== {1'b1, 14'h3F00, 1'b1})
            $display("FAIL wr_addr_dot: ale=%b addr=%h wr_n=%b required 1 3f00 1", O_vram_ale, O_vram_addr, O_vram_wr_n);
        else passes++;
        dot();
        checks++;
        if ({O_vram_wr_n, O_vram_oe, O_vram_wdata, O_vram_rd_n, O_vram_ale} !== {1'b0, 1'b1, 8'h21, 1'b1, 1'b0})
            $display("FAIL wr_data_dot: wr_n=%b oe=%b wdata=%h rd_n=%b ale=%b required 0 1 21 1 0",
                     O_vram_wr_n, O_vram_oe, O_vram_wdata, O_vram_rd_n, O_vram_ale);
        else passes++;
        dot();
        model_mem[14'h3F00] = 8'h21;
        checks++;
        if ({O_cpu_ack, O_cpu_busy, O_vram_wr_n, O_vram_oe} !== {1'b1, 1'b0, 1'b1, 1'b0})
            $display("FAIL wr_ack: ack=%b busy=%b wr_n=%b oe=%b required 1 0 1 0", O_cpu_ack, O_cpu_busy, O_vram_wr_n, O_vram_oe);
        else passes++;
        tick(1'b0);
        checks++;
        if (O_cpu_ack !== 1'b0 || vram[14'h3F00] !== 8'h21)
            $display("FAIL wr_done: ack=%b mem=%h required 0 21", O_cpu_ack, vram[14'h3F00]);
        else passes++;
    endtask

    task automatic test_cpu_deferred();
        bit act;
        bit got;
        logic [DW-1:0] exp;
        do_reset();
        set_mem(14'h2100, 8'h77);
        I_control = 16'h0400;
        I_cpu_we = 1'b0;
        I_cpu_addr = 14'h2100;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        act = 0;
        for (int k = 0; k < 12; k++) begin
            tick(k[0]);
            if (O_vram_ale || !O_vram_rd_n) act = 1;
        end
        checks++;
        if (act || O_cpu_busy !== 1'b1) $display("FAIL defer_while_rendering: activity=%b busy=%b required 0 1", act, O_cpu_busy);
        else passes++;
        // Second request while busy must be dropped.
        I_cpu_we = 1'b1;
        I_cpu_addr = 14'h2200;
        I_cpu_wdata = 8'h99;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        I_control = 16'h0000;
        got = 0;
        for (int k = 0; k < 24 && !got; k++) begin
            tick(k[0]);
            if (O_cpu_ack) got = 1;
        end
        model_read(14'h2100, exp);
        checks++;
        if (!got || O_cpu_rdata !== exp) $display("FAIL defer_read: ack=%b rdata=%h required 1 %h", got, O_cpu_rdata, exp);
        else passes++;
        act = 0;
        for (int k = 0; k < 12; k++) begin
            tick(k[0]);
            if (O_vram_ale || !O_vram_wr_n || O_cpu_busy) act = 1;
        end
        checks++;
        if (act || vram[14'h2200] !== model_mem[14'h2200])
            $display("FAIL ignored_req: activity=%b mem=%h required 0 %h", act, vram[14'h2200], model_mem[14'h2200]);
        else passes++;
    endtask

    task automatic test_render_miss();
        int m0;
        int ob;
        logic [DW-1:0] exp;
        do_reset();
        set_mem(14'h2401, 8'hC3);
        m0 = miss_cnt;
        ob = obs_q.size();
        I_cpu_we = 1'b0;
        I_cpu_addr = 14'h0123;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        dot();
        dot();
        checks++;
        if (O_vram_rd_n !== 1'b0 || O_vram_addr !== 14'h0123)
            $display("FAIL miss_cpu_data_dot: rd_n=%b addr=%h required 0 0123", O_vram_rd_n, O_vram_addr);
        else passes++;
        I_control = 16'h0402;
        I_render_addr = 14'h2400;
        dot();
        model_read(14'h0123, exp);
        checks++;
        if ({O_cpu_ack, O_render_miss, O_vram_ale, O_cpu_rdata} !== {1'b1, 1'b1, 1'b0, exp})
            $display("FAIL miss_pulse: ack=%b miss=%b ale=%b rdata=%h required 1 1 0 %h",
                     O_cpu_ack, O_render_miss, O_vram_ale, O_cpu_rdata, exp);
        else passes++;
        I_control = 16'h0408;
        I_render_addr = 14'h2401;
        tick(1'b0);
        checks++;
        if (O_render_miss !== 1'b0) $display("FAIL miss_pulse_width: miss=%b required 0", O_render_miss);
        else passes++;
        tick(1'b1);
        checks++;
        if (O_vram_ale !== 1'b1 || O_vram_addr !== 14'h2401)
            $display("FAIL miss_next_fetch_addr: ale=%b addr=%h required 1 2401", O_vram_ale, O_vram_addr);
        else passes++;
        I_control = 16'h0410;
        dot();
        I_control = 16'h0400;
        dot();
        tick(1'b0);
        checks++;
        if (obs_q.size() != ob + 1 || obs_q[obs_q.size()-1] !== 8'hC3 || miss_cnt - m0 != 1)
            $display("FAIL miss_next_fetch: fetches=%0d misses=%0d required 1 1", obs_q.size() - ob, miss_cnt - m0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [DW-1:0] exp;
        do_reset();
        I_cpu_we = 1'b1;
        I_cpu_addr = 14'h0500;
        I_cpu_wdata = 8'h44;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        dot();
        dot();
        tick(1'b0);
        // New strobe lands on the completing dot edge.
        I_cpu_we = 1'b0;
        I_cpu_addr = 14'h0500;
        I_cpu_req = 1'b1;
        tick(1'b1);
        I_cpu_req = 1'b0;
        model_mem[14'h0500] = 8'h44;
        checks++;
        if (O_cpu_ack !== 1'b1 || O_cpu_busy !== 1'b1)
            $display("FAIL b2b_ack_busy: ack=%b busy=%b required 1 1", O_cpu_ack, O_cpu_busy);
        else passes++;
        got = 0;
        for (int k = 0; k < 24 && !got; k++) begin
            tick(k[0]);
            if (O_cpu_ack) got = 1;
        end
        model_read(14'h0500, exp);
        checks++;
        if (!got || O_cpu_rdata !== exp || O_cpu_busy !== 1'b0)
            $display("FAIL b2b_second: ack=%b rdata=%h busy=%b required 1 %h 0", got, O_cpu_rdata, O_cpu_busy, exp);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit ack_seen;
        do_reset();
        set_mem(14'h0601, 8'hA5);
        I_control = 16'h0402;
        I_render_addr = 14'h0601;
        dot();
        I_control = 16'h0400;
        dot();
        I_control = 16'h0000;
        dot();
        I_cpu_we = 1'b1;
        I_cpu_addr = 14'h0600;
        I_cpu_wdata = 8'h55;
        I_cpu_req = 1'b1;
        tick(1'b0);
        I_cpu_req = 1'b0;
        dot();
        dot();
        I_reset = 1'b1;
        tick(1'b0);
        checks++;
        if (w_out_vec !== RST_OUT || O_dbg_state !== 3'd0)
            $display("FAIL reset_mid_values: got %h/%0d required %h/0", w_out_vec, O_dbg_state, RST_OUT);
        else passes++;
        I_reset = 1'b0;
        ack_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick(k[0]);
            if (O_cpu_ack || O_vram_ale) ack_seen = 1;
        end
        checks++;
        if (ack_seen || vram[14'h0600] !== model_mem[14'h0600])
            $display("FAIL reset_mid_no_ack: activity=%b mem=%h required 0 %h", ack_seen, vram[14'h0600], model_mem[14'h0600]);
        else passes++;
    endtask

    task automatic test_read_buffer();
        do_reset();
        set_mem(14'h2000, 8'h11);
        set_mem(14'h2001, 8'h22);
        set_mem(14'h3F00, 8'h0F);
        cpu_xfer(1'b0, 14'h2000, 8'h00);
        cpu_xfer(1'b0, 14'h2001, 8'h00);
        cpu_xfer(1'b0, 14'h3F00, 8'h00);
    endtask

    task automatic test_random_cpu();
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: a = AW'(32'h0700 + $urandom_range(0, 15));
                1: a = AW'(32'h3F00 + $urandom_range(0, 31));
                default: a = AW'($urandom_range(0, (1 << AW) - 1));
            endcase
            cpu_xfer(1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)));
            for (int g = $urandom_range(0, 3); g > 0; g--) tick(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_random_render();
        int ob;
        int m0;
        int odd;
        int nf;
        logic [AW-1:0] a;
        do_reset();
        exp_q.delete();
        ob = obs_q.size();
        m0 = miss_cnt;
        nf = 30;
        for (int i = 0; i < nf; i++) begin
            a = AW'($urandom_range(0, (1 << AW) - 1));
            odd = 2 * $urandom_range(0, 3) + 1;
            I_control = 16'h0400 | (16'd1 << odd);
            I_render_addr = a;
            exp_q.push_back(model_mem[a]);
            dot();
            I_control = 16'h0400 | (16'd1 << ((odd + 1) % 8));
            I_render_addr = AW'($urandom_range(0, (1 << AW) - 1));
            dot();
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                I_control = 16'h0400;
                dot();
            end
        end
        I_control = 16'h0400;
        dot();
        dot();
        tick(1'b0);
        checks++;
        if (obs_q.size() - ob != nf || miss_cnt != m0)
            $display("FAIL rand_render_count: fetches=%0d misses=%0d required %0d 0", obs_q.size() - ob, miss_cnt - m0, nf);
        else passes++;
        for (int i = 0; i < nf && ob + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[ob + i] !== exp_q[i])
                $display("FAIL rand_render_data[%0d]: got %h required %h", i, obs_q[ob + i], exp_q[i]);
            else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i] = DW'($urandom_range(0, 255));
            model_mem[i] = vram[i];
        end
        test_reset();
        test_render_fetch();
        test_cpu_write();
        test_cpu_deferred();
        test_render_miss();
        test_back_to_back();
        test_reset_mid();
        test_read_buffer();
        test_random_cpu();
        test_random_render();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
